// File: rtl/regfile_sb.sv
// 2-read/2-write register file with a per-register busy scoreboard and a busy counter.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy clears to the read ports.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd_addr1,
    output logic [XLEN-1:0] rd_data1,
    output logic            rd_busy1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_busy2,
    input  logic            wr_en0,
    input  logic [AW-1:0]   wr_addr0,
    input  logic [XLEN-1:0] wr_data0,
    input  logic            wr_en1,
    input  logic [AW-1:0]   wr_addr1,
    input  logic [XLEN-1:0] wr_data1,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic [AW-1:0]    rd_addr [2];
    logic [XLEN-1:0]  rd_data [2];
    logic             rd_busy [2];

    // Out-of-range addresses and a hardwired r0 behave as absent registers.
    function automatic logic legal(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++)
            n = n + (AW+1)'(v[i]);
        return n;
    endfunction

    logic wr_ok0, wr_ok1, iss_ok;
    assign wr_ok0 = wr_en0 && legal(wr_addr0);
    assign wr_ok1 = wr_en1 && legal(wr_addr1);
    assign iss_ok = iss_en && legal(iss_addr);

    // Issue is applied after the writeback clears so the younger producer keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok0)
            busy_nxt[wr_addr0] = 1'b0;
        if (wr_ok1)
            busy_nxt[wr_addr1] = 1'b0;
        if (iss_ok)
            busy_nxt[iss_addr] = 1'b1;
        if (flush)
            busy_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok0)
                regs[wr_addr0] <= wr_data0;
            if (wr_ok1)
                regs[wr_addr1] <= wr_data1;
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (legal(rd_addr[p])) begin
                rd_data[p] = regs[rd_addr[p]];
                rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
                // Forwarding is suppressed in reset so reads stay zero there.
                if (rst_n) begin
                    if (wr_ok1 && (wr_addr1 == rd_addr[p])) begin
                        rd_data[p] = wr_data1;
                        rd_busy[p] = 1'b0;
                    end else if (wr_ok0 && (wr_addr0 == rd_addr[p])) begin
                        rd_data[p] = wr_data0;
                        rd_busy[p] = 1'b0;
                    end
                    if (iss_ok && (iss_addr == rd_addr[p]))
                        rd_busy[p] = 1'b1;
                end
`endif
            end
        end
    end

    assign rd_data1 = rd_data[0];
    assign rd_busy1 = rd_busy[0];
    assign rd_data2 = rd_data[1];
    assign rd_busy2 = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised bench for regfile_sb (NREGS=24, ZERO_REG=1) against an array-based model.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

    localparam int NR = 24;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0;
    logic [31:0]   rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2;
    logic          wr_en0 = 1'b0, wr_en1 = 1'b0, iss_en = 1'b0, flush = 1'b0;
    logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0, iss_addr = '0;
    logic [31:0]   wr_data0 = '0, wr_data1 = '0;
    logic [AW:0]   busy_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit ok_addr(input int a);
        return (a < NR) && (a != 0);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++)
            n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input int a);
        if (!ok_addr(a)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en1 && int'(wr_addr1) == a) return wr_data1;
        if (wr_en0 && int'(wr_addr0) == a) return wr_data0;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!ok_addr(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (iss_en && int'(iss_addr) == a) return 1'b1;
        if ((wr_en1 && int'(wr_addr1) == a) || (wr_en0 && int'(wr_addr0) == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // Next-state rules: writes in port order, writeback clears, issue sets, flush clears all.
    function automatic void model_edge();
        int a0 = int'(wr_addr0), a1 = int'(wr_addr1), ia = int'(iss_addr);
        if (wr_en0 && ok_addr(a0)) begin m_reg[a0] = wr_data0; m_busy[a0] = 1'b0; end
        if (wr_en1 && ok_addr(a1)) begin m_reg[a1] = wr_data1; m_busy[a1] = 1'b0; end
        if (iss_en && ok_addr(ia)) m_busy[ia] = 1'b1;
        if (flush)
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endfunction

    task automatic step(input logic we0, input int a0, input logic [31:0] d0,
                        input logic we1, input int a1, input logic [31:0] d1,
                        input logic iss, input int ia, input logic fl,
                        input int r1, input int r2);
        wr_en0 = we0; wr_addr0 = AW'(a0); wr_data0 = d0;
        wr_en1 = we1; wr_addr1 = AW'(a1); wr_data1 = d1;
        iss_en = iss; iss_addr = AW'(ia); flush = fl;
        rd_addr1 = AW'(r1); rd_addr2 = AW'(r2);
        #1;
        check("rd_data1", rd_data1, exp_data(r1));
        check("rd_busy1", 32'(rd_busy1), 32'(exp_busy(r1)));
        check("rd_data2", rd_data2, exp_data(r2));
        check("rd_busy2", 32'(rd_busy2), 32'(exp_busy(r2)));
        @(posedge clk);
        model_edge();
        #1;
        check("busy_cnt", 32'(busy_cnt), 32'(model_cnt()));
    endtask

    task automatic idle(input int r1, input int r2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        model_clear();
        #3;
        check("reset_rd_data1", rd_data1, 32'h0);
        check("reset_busy_cnt", 32'(busy_cnt), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 5, 0);
        step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 5, 0);
        idle(0, 5);
        step(1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0, 0, 7, 7);
        idle(7, 5);
        check("same_addr_port1_wins", rd_data1, 32'h5555);

        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 4);
        step(0, 0, 0, 0, 0, 0, 1, 4, 0, 3, 4);
        check("two_issues_cnt", 32'(busy_cnt), 32'd2);
        step(1, 3, 32'h33, 0, 0, 0, 1, 3, 0, 3, 4);
        idle(3, 4);
        check("issue_beats_wb", 32'(rd_busy1), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 6, 1, 3, 6);
        check("flush_cnt", 32'(busy_cnt), 32'd0);

        step(1, 9, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 9);
        step(0, 0, 0, 1, 9, 32'hBEEF, 0, 0, 0, 9, 9);
        idle(9, 9);

        step(0, 0, 0, 0, 0, 0, 1, 10, 0, 10, 30);
        step(1, 30, 32'hDEAD, 0, 0, 0, 1, 30, 0, 30, 10);
        check("illegal_iss_cnt", 32'(busy_cnt), 32'd1);
        idle(30, 31);

        step(1, 12, 32'hCAFE, 1, 13, 32'hF00D, 1, 14, 0, 12, 13);
        #2 rst_n = 1'b0;
        rd_addr1 = AW'(12); rd_addr2 = AW'(14);
        #1;
        model_clear();
        check("async_reset_rd12", rd_data1, 32'h0);
        check("async_reset_busy14", 32'(rd_busy2), 32'h0);
        check("async_reset_cnt", 32'(busy_cnt), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(12, 14);

        for (int i = 0; i < 600; i++) begin
            int a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            int a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            int ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), a0, $urandom,
                 1'($urandom_range(0, 1)), a1, $urandom,
                 1'($urandom_range(0, 2) != 0), ia, 1'($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
